hamming_decoder: RTL
====================

HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, listed first:
  clk       in   1  rising-edge clock
  rst       in   1  synchronous, active-high reset
REQ-002 It SHALL have these further ports:
  in_valid  in   1  codeword offered
  in_ready  out  1  decoder accepts codeword
  codeword  in   7  Hamming [7,4] word; bit i = position i+1
  out_valid out  1  decoded word available
  out_ready in   1  downstream accepts
  data      out  4  corrected data {d3,d2,d1,d0}
  corrected out  1  single-bit error was corrected
  syndrome  out  3  {s4,s2,s1}; 0 = clean, else error position 1..7
  clr_cnt   in   1  clear counters
  word_cnt  out  16 accepted output words, wraps
  corr_cnt  out  16 corrected words, saturates at 0xFFFF

Function
REQ-003 The codeword layout SHALL be: cw[0]=p1, cw[1]=p2, cw[2]=d0, cw[3]=p4, cw[4]=d1, cw[5]=d2, cw[6]=d3.
REQ-004 Parity SHALL be even: p1=d0^d1^d3, p2=d0^d2^d3, p4=d1^d2^d3.
REQ-005 Syndrome SHALL be: s1=cw0^cw2^cw4^cw6, s2=cw1^cw2^cw5^cw6, s4=cw3^cw4^cw5^cw6.
REQ-006 If the syndrome is nonzero, the decoder SHALL invert cw[syndrome-1] before extracting data, and SHALL set corrected=1; otherwise it SHALL set corrected=0.
REQ-007 Correction SHALL be single-error only: a double error produces a nonzero syndrome and is miscorrected, with no separate detection.
REQ-008 The datapath SHALL be a 2-stage pipeline.
  - Stage 1 registers the codeword and the syndrome.
  - Stage 2 registers data, corrected and syndrome.
REQ-009 Latency SHALL be exactly 2 cycles from the in_valid&&in_ready edge to out_valid=1 when out_ready is held at 1.
REQ-010 Each stage SHALL advance when it is empty or when the next stage advances. Output stage advances = !out_valid || out_ready.
REQ-011 in_ready SHALL be !s1_valid || s1_advance, so that full throughput is one word per cycle with out_ready=1.
REQ-012 While out_valid=1 and out_ready=0, data, corrected and syndrome SHALL hold stable. No word SHALL be dropped or duplicated.
REQ-013 When stage 1 and stage 2 are full and out_ready=0, in_ready SHALL be 0.
REQ-014 word_cnt SHALL increment on each out_valid&&out_ready, wrapping 0xFFFF->0.
REQ-015 corr_cnt SHALL increment on each out_valid&&out_ready with corrected=1, holding at 0xFFFF.
REQ-016 When clr_cnt=1, both counters SHALL be 0 next cycle. clr_cnt SHALL take priority over a simultaneous increment, and that increment is lost.
REQ-017 in_valid SHALL be ignored when in_ready=0. codeword SHALL be sampled only on handshake.

Reset
REQ-018 When rst=1 on a clock edge, all valid flags, data, corrected, syndrome, word_cnt and corr_cnt SHALL be 0.
REQ-019 Reset mid-stream SHALL discard all in-flight words; no output SHALL appear for them.
REQ-020 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-021 rst SHALL take priority over clr_cnt and over handshakes.

Structure
REQ-022 Package hamming_pkg SHALL hold:
  - constants DATA_W=4, CODE_W=7, SYN_W=3;
  - typedefs data_t, code_t, syn_t;
  - pure functions calc_syndrome(code_t) and extract_data(code_t).
REQ-023 hamming_pkg SHALL be usable by an encoder for parity generation.
REQ-024 A sub-module hamming_sec_counter SHALL implement the word and correction counters: clear, wrap and saturate.
REQ-025 hamming_decoder SHALL instantiate hamming_sec_counter alongside the 2-stage pipeline.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Clean words, out_ready=1: 0x1E, 0x2D, 0x7F on consecutive cycles -> data 0x3, 0x5, 0xF on cycles +2, +3, +4; corrected=0; syndrome=0; word_cnt=3.
  - Single error: 0x0E (0x1E with cw[4] flipped) -> data=0x3, syndrome=5, corrected=1, corr_cnt=1. Flip each bit 0..6 of 0x7F -> data=0xF, syndrome=bit+1.
  - Backpressure: 4 words with out_ready=0 -> in_ready=0 after 2 accepted; outputs stable; release -> 4 outputs in order, none lost.
  - Counter edges: preload via 65535 corrected words -> corr_cnt holds 0xFFFF. word_cnt wraps to 0. clr_cnt with a simultaneous handshake -> both counters 0.
  - Reset mid-operation: rst while 2 words are in flight -> out_valid=0, counters 0, in_ready=1 next cycle, no stale output.
  - Random: 10k random data with 0 or 1 injected errors, random out_ready -> scoreboard matches original data and the expected counts.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming [7,4] definitions: widths, types and the pure parity/syndrome
// helpers used by both the decoder and any matching encoder.
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;
  localparam int SYN_W  = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [SYN_W-1:0]  syn_t;

  // Bit i of the codeword is position i+1; parity bits sit at positions 1, 2 and 4.
  function automatic syn_t calc_syndrome(code_t cw);
    syn_t s;
    s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return s;
  endfunction

  function automatic data_t extract_data(code_t cw);
    return {cw[6], cw[5], cw[4], cw[2]};
  endfunction

  function automatic code_t encode(data_t d);
    code_t cw;
    cw[2] = d[0];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[3] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_decoder_if.sv
// Stream bundle around the decoder: codeword in, corrected word out, counter access.
interface hamming_decoder_if
  import hamming_pkg::*;
();
  logic        in_valid;
  logic        in_ready;
  code_t       codeword;
  logic        out_valid;
  logic        out_ready;
  data_t       data;
  logic        corrected;
  syn_t        syndrome;
  logic        clr_cnt;
  logic [15:0] word_cnt;
  logic [15:0] corr_cnt;

  modport master (
    output in_valid, codeword, out_ready, clr_cnt,
    input  in_ready, out_valid, data, corrected, syndrome, word_cnt, corr_cnt
  );

  modport slave (
    input  in_valid, codeword, out_ready, clr_cnt,
    output in_ready, out_valid, data, corrected, syndrome, word_cnt, corr_cnt
  );
endinterface

// File: rtl/hamming_sec_counter.sv
// Accepted-word counter (wrapping) and corrected-word counter (saturating),
// both cleared by clr_i, which wins over a same-cycle increment.
module hamming_sec_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        word_inc_i,
  input  logic        corr_inc_i,
  output logic [15:0] word_cnt_o,
  output logic [15:0] corr_cnt_o
);

  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] corr_cnt_q, corr_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    corr_cnt_d = corr_cnt_q;
    if (clr_i) begin
      word_cnt_d = '0;
      corr_cnt_d = '0;
    end else begin
      if (word_inc_i)
        word_cnt_d = word_cnt_q + 16'd1;
      if (corr_inc_i && corr_cnt_q != 16'hFFFF)
        corr_cnt_d = corr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q <= '0;
      corr_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      corr_cnt_q <= corr_cnt_d;
    end
  end

  assign word_cnt_o = word_cnt_q;
  assign corr_cnt_o = corr_cnt_q;

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage single-error-correcting Hamming [7,4] decoder with valid/ready flow
// control: stage 1 holds codeword+syndrome, stage 2 holds the corrected result.
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  code_t       codeword,
  output logic        out_valid,
  input  logic        out_ready,
  output data_t       data,
  output logic        corrected,
  output syn_t        syndrome,
  input  logic        clr_cnt,
  output logic [15:0] word_cnt,
  output logic [15:0] corr_cnt
);

  logic  s1_valid_q;
  code_t s1_code_q;
  syn_t  s1_syn_q;

  logic  s2_valid_q;
  data_t s2_data_q, s2_data_d;
  logic  s2_corr_q, s2_corr_d;
  syn_t  s2_syn_q;

  logic  s1_adv, s2_adv;
  code_t fixed_code;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // A nonzero syndrome names the 1-based position of the bit to invert.
  for (genvar gi = 0; gi < CODE_W; gi++) begin : g_fix
    assign fixed_code[gi] = s1_code_q[gi] ^ (s1_syn_q == syn_t'(gi + 1));
  end

  always_comb begin
    s2_data_d = extract_data(fixed_code);
    s2_corr_d = |s1_syn_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_corr_q  <= 1'b0;
      s2_syn_q   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_code_q <= codeword;
          s1_syn_q  <= calc_syndrome(codeword);
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s2_data_d;
          s2_corr_q <= s2_corr_d;
          s2_syn_q  <= s1_syn_q;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign data      = s2_data_q;
  assign corrected = s2_corr_q;
  assign syndrome  = s2_syn_q;

  hamming_sec_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_cnt),
    .word_inc_i (s2_valid_q && out_ready),
    .corr_inc_i (s2_valid_q && out_ready && s2_corr_q),
    .word_cnt_o (word_cnt),
    .corr_cnt_o (corr_cnt)
  );

endmodule
